conv_line_feeder: RTL

Streams an image frame from a word-addressed frame memory into the convolution front end, one line buffer at a time. It is the writer side of the conv input interface and drives data, wr_en and the target-buffer select k. It primes all three line buffers and then refills one buffer per ready request, rotating the target buffer. Each line is WORDS_PER_LINE 32-bit words of 4 packed pixels.

---
 rtl/conv_line_feeder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/conv_line_feeder.sv
// conv_line_feeder: streams a frame from word-addressed memory into the conv
// line buffers. It primes three lines (k=0), then refills one line per ready
// request with k rotating 1,2,3.
// Optional build macro CONV_FEEDER_PAD_EN adds one all-zero line before and
// one after the image lines.
module conv_line_feeder #(
  parameter int unsigned WORDS_PER_LINE = 25,
  parameter int unsigned NUM_LINES      = 100,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] data,
  output logic              wr_en,
  output logic [1:0]        k,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PRIME_WORDS = 3 * WORDS_PER_LINE;
  localparam int unsigned WORD_W      = $clog2(3 * WORDS_PER_LINE + 1);
  localparam int unsigned LINE_W      = $clog2(NUM_LINES + 3);
`ifdef CONV_FEEDER_PAD_EN
  localparam int unsigned TOTAL_LINES = NUM_LINES + 2;
`else
  localparam int unsigned TOTAL_LINES = NUM_LINES;
`endif

  if (NUM_LINES < 3) begin : g_bad_num_lines
    $error("conv_line_feeder: NUM_LINES must be >= 3");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_WAIT_RDY, S_LINE, S_FINISH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          ktgt_q, ktgt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                slot_q, slot_d;
  logic                slot_zero_q, slot_zero_d;
  logic [1:0]          slot_k_q, slot_k_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_zero_q, wr_zero_d;
  logic [1:0]          k_q, k_d;

  logic                issue, zero_slot, in_prime, last_slot;
  logic [ADDR_W-1:0]   cur_addr;
  logic [WORD_W-1:0]   word_cur;

  // Next-state: slot issue, address/word/line counters, output pipeline
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    line_d      = line_q;
    ktgt_d      = ktgt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    slot_k_d    = slot_k_q;
    issue       = 1'b0;
    zero_slot   = 1'b0;
    in_prime    = 1'b0;
    last_slot   = 1'b0;
    cur_addr    = addr_q;
    word_cur    = word_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr = base_addr;
          addr_d   = base_addr;
          word_cur = '0;
          line_d   = '0;
          ktgt_d   = 2'd0;
          busy_d   = 1'b1;
          issue    = 1'b1;
          state_d  = S_PRIME;
        end
      end
      S_PRIME: issue = 1'b1;
      S_WAIT_RDY: begin
        if (line_q == LINE_W'(TOTAL_LINES)) begin
          state_d = S_FINISH;
        end else if (ready) begin
          ktgt_d  = (ktgt_q == 2'd3) ? 2'd1 : ktgt_q + 2'd1;
          issue   = 1'b1;
          state_d = S_LINE;
        end
      end
      S_LINE: issue = 1'b1;
      S_FINISH: begin
        // last slot has moved on to wr_en; done lands one cycle after it
        if (!slot_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_prime = (state_d == S_PRIME);
`ifdef CONV_FEEDER_PAD_EN
    zero_slot = in_prime ? (word_cur < WORD_W'(WORDS_PER_LINE))
                         : (line_q == LINE_W'(NUM_LINES + 1));
`endif

    if (issue) begin
      last_slot = in_prime ? (word_cur == WORD_W'(PRIME_WORDS - 1))
                           : (word_cur == WORD_W'(WORDS_PER_LINE - 1));
      slot_k_d  = in_prime ? 2'd0 : ktgt_d;
      if (!zero_slot) begin
        rd_en_d   = 1'b1;
        rd_addr_d = cur_addr;
        addr_d    = cur_addr + ADDR_W'(1);
      end
      if (last_slot) begin
        word_d  = '0;
        line_d  = in_prime ? LINE_W'(3) : line_q + LINE_W'(1);
        state_d = S_WAIT_RDY;
      end else begin
        word_d  = word_cur + WORD_W'(1);
      end
    end

    slot_d      = issue;
    slot_zero_d = issue & zero_slot;
    wr_en_d     = slot_q;
    wr_zero_d   = slot_zero_q;
    k_d         = slot_q ? slot_k_q : k_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      line_q      <= '0;
      ktgt_q      <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      slot_q      <= 1'b0;
      slot_zero_q <= 1'b0;
      slot_k_q    <= 2'd0;
      wr_en_q     <= 1'b0;
      wr_zero_q   <= 1'b0;
      k_q         <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      line_q      <= line_d;
      ktgt_q      <= ktgt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      slot_q      <= slot_d;
      slot_zero_q <= slot_zero_d;
      slot_k_q    <= slot_k_d;
      wr_en_q     <= wr_en_d;
      wr_zero_q   <= wr_zero_d;
      k_q         <= k_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign wr_en       = wr_en_q;
  assign k           = k_q;
  assign busy        = busy_q;
  assign done        = done_q;
  // Memory data arrives in the wr_en cycle itself; forward it under the
  // registered qualifiers so padding slots and idle cycles present zero.
  assign data        = (wr_en_q && !wr_zero_q) ? mem_rd_data : '0;

endmodule
